// File: rtl/ws2812_pkg.sv
// Shared WS2812 line timing and FSM encoding, used by both receiver and transmitter.
package ws2812_pkg;

    // Nominal bit timing in 50 MHz clk cycles
    localparam int unsigned T0H   = 20;
    localparam int unsigned T1H   = 40;
    localparam int unsigned TOTAL = 62;

    localparam int unsigned CLK_THRESH = 30;
    localparam int unsigned MIN_HIGH   = 8;
    localparam int unsigned MAX_HIGH   = 60;
    localparam int unsigned RESET_CYC  = 2500;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ws2812_receiver.sv
// WS2812 pulse-width decoder: assembles 24-bit pixels, detects frame end and forwards
// the remainder of the stream once the first CONSUME pixels have been taken.
module ws2812_receiver #(
    parameter int unsigned CLK_THRESH = ws2812_pkg::CLK_THRESH,
    parameter int unsigned MIN_HIGH   = ws2812_pkg::MIN_HIGH,
    parameter int unsigned MAX_HIGH   = ws2812_pkg::MAX_HIGH,
    parameter int unsigned RESET_CYC  = ws2812_pkg::RESET_CYC,
    parameter int unsigned CONSUME    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] pixel_count,
    output logic        frame_done,
    output logic        err,
    output logic        dout,
    output logic        busy
);

    import ws2812_pkg::*;

    logic        din_s;
    logic        din_d;
    logic        rise;
    logic        fall;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [11:0] cnt_q;
    logic [12:0] width;
    logic        bad_width;
    logic        bit_val;
    logic        classify;
    logic        frame_end;
    logic        consumed;
    logic        fwd_q;
    logic        fwd_d;
    logic [23:0] shift_q;
    logic [4:0]  bit_cnt_q;

    sync2 u_sync2 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (din),
        .q       (din_s)
    );

    assign rise = din_s & ~din_d;
    assign fall = ~din_s & din_d;

    // The counter clears on the edge itself, so the pulse width is one more than its value
    assign width     = {1'b0, cnt_q} + 13'd1;
    assign bad_width = (width < 13'(MIN_HIGH)) || (width > 13'(MAX_HIGH));
    assign bit_val   = (width >= 13'(CLK_THRESH));
    assign classify  = (state_q == ST_HIGH) && fall;
    assign frame_end = (state_q == ST_LOW) && !rise && (width >= 13'(RESET_CYC));
    assign consumed  = ({16'd0, pixel_count} >= CONSUME);

    // frame_done guards the cycle where pixel_count still holds the previous frame's total
    always_comb begin
        fwd_d = fwd_q | (rise & consumed & ~frame_done);
        if (frame_end) begin
            fwd_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (rise) state_d = ST_HIGH;
            ST_HIGH: if (fall) state_d = ST_LOW;
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (frame_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            din_d       <= 1'b0;
            cnt_q       <= 12'd0;
            shift_q     <= 24'd0;
            bit_cnt_q   <= 5'd0;
            pixel_data  <= 24'd0;
            pixel_valid <= 1'b0;
            pixel_count <= 16'd0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            fwd_q       <= 1'b0;
            dout        <= 1'b0;
        end else begin
            state_q     <= state_d;
            din_d       <= din_s;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            fwd_q       <= fwd_d;
            dout        <= fwd_d & din_s;

            if (rise || fall) begin
                cnt_q <= 12'd0;
            end else if (cnt_q != 12'hFFF) begin
                cnt_q <= cnt_q + 12'd1;
            end

            if (classify) begin
                if (bad_width) begin
                    err       <= 1'b1;
                    shift_q   <= 24'd0;
                    bit_cnt_q <= 5'd0;
                end else if (bit_cnt_q == 5'd23) begin
                    pixel_data  <= {shift_q[22:0], bit_val};
                    pixel_valid <= 1'b1;
                    if (pixel_count != 16'hFFFF) begin
                        pixel_count <= pixel_count + 16'd1;
                    end
                    shift_q   <= 24'd0;
                    bit_cnt_q <= 5'd0;
                end else begin
                    shift_q   <= {shift_q[22:0], bit_val};
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                end
            end

            if (frame_end) begin
                frame_done <= 1'b1;
                busy       <= 1'b0;
                if (bit_cnt_q != 5'd0) begin
                    err <= 1'b1;
                end
                shift_q   <= 24'd0;
                bit_cnt_q <= 5'd0;
            end

            if (frame_done) begin
                pixel_count <= 16'd0;
            end

            if ((state_q == ST_IDLE) && rise) begin
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_receiver.sv
// Directed bench for ws2812_receiver: one task per scenario with inline checks.
module tb_ws2812_receiver;

    logic        clk;
    logic        reset_n;
    logic        din;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [15:0] pixel_count;
    logic        frame_done;
    logic        err;
    logic        dout;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Strobe monitor state
    int          cyc = 0;
    int          pv_cnt = 0;
    int          fd_cnt = 0;
    int          err_cnt = 0;
    int          fd_cyc = -1;
    int          err_cyc = -2;
    logic [23:0] last_data = 24'd0;
    logic        mon_dout = 1'b0;
    logic        arm_fwd = 1'b0;
    int          fwd_start = -1;
    int          dout_bad = 0;
    int          dout_hi = 0;
    logic [2:0]  hist = 3'b000;

    ws2812_receiver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_count (pixel_count),
        .frame_done  (frame_done),
        .err         (err),
        .dout        (dout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dout must equal din three cycles earlier (two sync flops plus the output register)
    always @(negedge clk) begin
        logic exp_dout;
        cyc = cyc + 1;
        if (pixel_valid === 1'b1) begin
            pv_cnt    = pv_cnt + 1;
            last_data = pixel_data;
        end
        if (frame_done === 1'b1) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
        if (err === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (arm_fwd && din === 1'b1 && fwd_start < 0) begin
            fwd_start = cyc;
        end
        if (mon_dout) begin
            exp_dout = (fwd_start >= 0 && cyc >= fwd_start + 3) ? hist[2] : 1'b0;
            if (dout !== exp_dout) dout_bad = dout_bad + 1;
            if (dout === 1'b1) dout_hi = dout_hi + 1;
        end
        hist = {hist[1:0], din};
    end

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 din = v;
        end
    endtask

    task automatic send_bit(input logic b);
        hold(1'b1, b ? 40 : 20);
        hold(1'b0, b ? 22 : 42);
    endtask

    task automatic send_pixel(input logic [23:0] v);
        for (int i = 23; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic clr_mon();
        pv_cnt   = 0;
        fd_cnt   = 0;
        err_cnt  = 0;
        fd_cyc   = -1;
        err_cyc  = -2;
        dout_bad = 0;
        dout_hi  = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        din     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pixel_data !== 24'd0) begin errors++; $display("FAIL reset_pixel_data got=%h want=000000", pixel_data); end
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pixel_valid got=%b want=0", pixel_valid); end
        checks++; if (pixel_count !== 16'd0) begin errors++; $display("FAIL reset_pixel_count got=%0d want=0", pixel_count); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout got=%b want=0", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        hold(1'b0, 5);
    endtask

    task automatic test_single_pixel();
        logic [23:0] v;
        v = 24'hA5C33C;
        clr_mon();
        for (int i = 23; i >= 1; i--) begin
            send_bit(v[i]);
            if (i == 20) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid got=%b want=1", busy); end
            end
        end
        hold(1'b1, 20);
        @(posedge clk);
        #1 din = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got=%b want=0", pixel_valid); end
        @(posedge clk);
        #1;
        checks++; if (pixel_valid !== 1'b1) begin errors++; $display("FAIL single_valid_at3 got=%b want=1", pixel_valid); end
        checks++; if (pixel_data !== 24'hA5C33C) begin errors++; $display("FAIL single_data got=%h want=a5c33c", pixel_data); end
        checks++; if (pixel_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d want=1", pixel_count); end
        hold(1'b0, 3000);
        checks++; if (pv_cnt !== 1) begin errors++; $display("FAIL single_valid_count got=%0d want=1", pv_cnt); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL single_frame_done got=%0d want=1", fd_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL single_err got=%0d want=0", err_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b want=0", busy); end
        checks++; if (pixel_count !== 16'd0) begin errors++; $display("FAIL single_count_clear got=%0d want=0", pixel_count); end
    endtask

    task automatic test_forward();
        clr_mon();
        fwd_start = -1;
        arm_fwd   = 1'b0;
        mon_dout  = 1'b1;
        send_pixel(24'h123456);
        arm_fwd = 1'b1;
        send_pixel(24'hABCDEF);
        send_pixel(24'h0F0F0F);
        checks++; if (pixel_count !== 16'd3) begin errors++; $display("FAIL fwd_count got=%0d want=3", pixel_count); end
        hold(1'b0, 3000);
        mon_dout = 1'b0;
        arm_fwd  = 1'b0;
        checks++; if (pv_cnt !== 3) begin errors++; $display("FAIL fwd_valid_count got=%0d want=3", pv_cnt); end
        checks++; if (last_data !== 24'h0F0F0F) begin errors++; $display("FAIL fwd_last_data got=%h want=0f0f0f", last_data); end
        checks++; if (dout_bad !== 0) begin errors++; $display("FAIL fwd_dout_track got=%0d bad cycles want=0", dout_bad); end
        // 29 ones at 40 cycles plus 19 zeros at 20 cycles across pixels 2 and 3
        checks++; if (dout_hi !== 1540) begin errors++; $display("FAIL fwd_dout_high got=%0d want=1540", dout_hi); end
        checks++; if (pixel_count !== 16'd0) begin errors++; $display("FAIL fwd_count_clear got=%0d want=0", pixel_count); end
    endtask

    task automatic test_glitch();
        clr_mon();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        hold(1'b1, 4);
        hold(1'b0, 58);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL glitch_err got=%0d want=1", err_cnt); end
        send_pixel(24'h5A5A5A);
        checks++; if (pv_cnt !== 1) begin errors++; $display("FAIL glitch_valid_count got=%0d want=1", pv_cnt); end
        checks++; if (last_data !== 24'h5A5A5A) begin errors++; $display("FAIL glitch_data got=%h want=5a5a5a", last_data); end
        hold(1'b0, 3000);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL glitch_err_total got=%0d want=1", err_cnt); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL glitch_frame_done got=%0d want=1", fd_cnt); end
    endtask

    task automatic test_thresholds();
        clr_mon();
        hold(1'b1, 29);
        hold(1'b0, 33);
        hold(1'b1, 30);
        hold(1'b0, 32);
        for (int i = 0; i < 22; i++) send_bit(1'b0);
        checks++; if (last_data !== 24'h400000) begin errors++; $display("FAIL thresh_data got=%h want=400000", last_data); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL thresh_err_none got=%0d want=0", err_cnt); end
        hold(1'b1, 61);
        hold(1'b0, 40);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL thresh_long_err got=%0d want=1", err_cnt); end
        hold(1'b0, 3000);
        checks++; if (pv_cnt !== 1) begin errors++; $display("FAIL thresh_valid_count got=%0d want=1", pv_cnt); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL thresh_err_total got=%0d want=1", err_cnt); end
    endtask

    task automatic test_partial_frame();
        clr_mon();
        for (int i = 0; i < 12; i++) send_bit(i[1]);
        hold(1'b0, 2600);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL partial_err got=%0d want=1", err_cnt); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL partial_frame_done got=%0d want=1", fd_cnt); end
        checks++; if (err_cyc !== fd_cyc) begin errors++; $display("FAIL partial_same_cycle got=%0d want=%0d", err_cyc, fd_cyc); end
        checks++; if (pv_cnt !== 0) begin errors++; $display("FAIL partial_no_valid got=%0d want=0", pv_cnt); end
        checks++; if (pixel_count !== 16'd0) begin errors++; $display("FAIL partial_count got=%0d want=0", pixel_count); end
    endtask

    task automatic test_reset_midword();
        send_pixel(24'h00FF00);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        hold(1'b1, 15);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got=%b want=1", busy); end
        checks++; if (pixel_count !== 16'd1) begin errors++; $display("FAIL midreset_count_before got=%0d want=1", pixel_count); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pixel_data, pixel_valid, pixel_count, frame_done, err, dout, busy} !== 45'd0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h/%b/%0d/%b/%b/%b/%b want=all zero",
                     pixel_data, pixel_valid, pixel_count, frame_done, err, dout, busy);
        end
        din = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        clr_mon();
        hold(1'b0, 10);
        send_pixel(24'h00FF00);
        hold(1'b0, 3000);
        checks++; if (pv_cnt !== 1) begin errors++; $display("FAIL midreset_valid_count got=%0d want=1", pv_cnt); end
        checks++; if (last_data !== 24'h00FF00) begin errors++; $display("FAIL midreset_data got=%h want=00ff00", last_data); end
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL midreset_frame_done got=%0d want=1", fd_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL midreset_err got=%0d want=0", err_cnt); end
    endtask

    initial begin
        reset_n = 1'b0;
        din     = 1'b0;
        test_reset();
        test_single_pixel();
        test_forward();
        test_glitch();
        test_thresholds();
        test_partial_frame();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ws2812_receiver.md
WS2812_RECEIVER -- requirements
Module: ws2812_receiver

Interface
REQ-001 Parameter CLK_THRESH, default 30, is the minimum high width in clk cycles that decodes as bit 1; shorter valid pulses decode as bit 0.
REQ-002 Parameter MIN_HIGH, default 8, is the minimum legal high width in cycles; shorter pulses are glitches.
REQ-003 Parameter MAX_HIGH, default 60, is the maximum legal high width in cycles; longer pulses are errors.
REQ-004 Parameter RESET_CYC, default 2500, is the low width in cycles that ends a frame (50 us at 50 MHz).
REQ-005 Parameter CONSUME, default 1, is the number of pixels consumed before forwarding starts.
REQ-006 clk  input  1  50 MHz system clock; the block has one clock.
REQ-007 reset_n  input  1  reset, asynchronous and active-low.
REQ-008 din  input  1  asynchronous WS2812 serial line.
REQ-009 pixel_data  output  24  last decoded pixel, MSB first as received (GRB order untouched).
REQ-010 pixel_valid  output  1  one-cycle strobe; pixel_data is new.
REQ-011 pixel_count  output  16  pixels decoded in the current frame.
REQ-012 frame_done  output  1  one-cycle strobe at the end of a frame.
REQ-013 err  output  1  one-cycle strobe on a protocol error.
REQ-014 dout  output  1  forwarded stream for daisy-chaining.
REQ-015 busy  output  1  high from the first rising edge of a frame until frame_done.

Function
REQ-016 din shall pass through a two-flop synchronizer; din_s is the second flop, and edges are detected against a registered copy of din_s.
REQ-017 The FSM shall have three states.
- IDLE: waits for a rising edge, then goes to HIGH.
- HIGH: counts high cycles; on a falling edge, classifies the pulse and goes to LOW.
- LOW: counts low cycles; a rising edge goes to HIGH; reaching RESET_CYC goes to IDLE.
REQ-018 The width counter shall be 12 bits, clear on every edge, and saturate at 4095.
REQ-019 Pulse classification at the falling edge:
- width < MIN_HIGH or > MAX_HIGH: err, and the partial word plus bit counter are cleared.
- width >= CLK_THRESH: bit 1.
- otherwise: bit 0.
REQ-020 Decoded bits shall shift MSB-first into a 24-bit register.
REQ-021 On the 24th bit, pixel_data and pixel_valid shall update on the next clock edge: 3 cycles after the din falling edge.
REQ-022 pixel_count shall increment with pixel_valid and saturate at 65535.
REQ-023 On reaching RESET_CYC in LOW:
- frame_done pulses once.
- busy clears.
- pixel_count clears on the following cycle.
- forwarding disables.
REQ-024 If the bit counter is nonzero at frame end, err shall pulse in the same cycle as frame_done and the partial word shall be discarded with no pixel_valid.
REQ-025 frame_done shall not repeat while the line stays low in IDLE.
REQ-026 dout shall be 0 until CONSUME pixels are decoded in the frame, then equal din_s registered one cycle, starting at the next rising edge.
REQ-027 If a rising edge and counter saturation coincide, the rising edge shall win.

Reset
REQ-028 While reset_n is low, all of the following shall be 0 and the state shall be IDLE: pixel_data, pixel_valid, pixel_count, frame_done, err, dout, busy, the synchronizer and the counters.
REQ-029 Reset asserted mid-word shall discard the word; after release, the next frame shall decode normally with no spurious strobes.

Structure
REQ-030 A shared package ws2812_pkg shall hold the timing constants (T0H=20, T1H=40, TOTAL=62, CLK_THRESH, MIN_HIGH, MAX_HIGH, RESET_CYC) and the FSM state encoding, shared with the transmitter.
REQ-031 One sub-module, sync2 (the two-flop synchronizer), shall be instantiated; all other logic shall be flat.

Verification
REQ-032 Single pixel 0xA5C33C (T0H=20, T1H=40, period 62) then a 3000-cycle low -> pixel_valid once with 0xA5C33C, 3 cycles after the 24th falling edge; frame_done once; pixel_count 1.
REQ-033 Three pixels, CONSUME=1 -> 3 pixel_valid strobes; dout stays 0 through pixel 1 and equals din_s delayed for pixels 2-3; pixel_count reaches 3.
REQ-034 A 4-cycle glitch after 10 bits -> err strobe and the word is discarded; the next 24 clean bits decode to the correct value.
REQ-035 High widths 29 and 30 -> bits 0 and 1 respectively; a 61-cycle high -> err.
REQ-036 12 bits then a 2600-cycle low -> err and frame_done in the same cycle, no pixel_valid, pixel_count returns to 0.
REQ-037 reset_n pulsed low mid-word -> all outputs 0 immediately; a following frame of 0x00FF00 decodes correctly.
